// File: rtl/ps2_rx_pkg.sv
// Shared constants and helpers for the serial keyboard receive path.
package ps2_rx_pkg;

  // Level both pins float to when nothing is transmitting.
  localparam logic LINE_IDLE_LEVEL = 1'b1;

  // Start + 8 data + parity + stop, shared with the frame shift register.
  localparam int unsigned FRAME_BITS = 11;

  // Bits needed for a counter holding values 0..n-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ps2_line_conditioner_if.sv
// Pin-side raw lines in, conditioned levels and strobes out.
interface ps2_line_conditioner_if;
  logic RAW_CLOCK;
  logic RAW_DATA;
  logic CONTROL_CLOCK;
  logic DEBOUNCED_DATA;
  logic FALL_STROBE;
  logic DATA_AT_FALL;
  logic FRAME_RESET;
  logic LINE_IDLE;

  // Pin side: drives the raw lines, observes the conditioned outputs.
  modport master (
    output RAW_CLOCK, RAW_DATA,
    input  CONTROL_CLOCK, DEBOUNCED_DATA, FALL_STROBE, DATA_AT_FALL,
           FRAME_RESET, LINE_IDLE
  );

  // Conditioner side.
  modport slave (
    input  RAW_CLOCK, RAW_DATA,
    output CONTROL_CLOCK, DEBOUNCED_DATA, FALL_STROBE, DATA_AT_FALL,
           FRAME_RESET, LINE_IDLE
  );
endinterface

// File: rtl/line_debounce_filter.sv
// Two-flop synchroniser followed by a persistence filter for one raw line.
module line_debounce_filter
  import ps2_rx_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic flip_c
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] count;

  // Stable value changes on this edge: disagreement has persisted long enough.
  assign flip_c = (sync2 != stable) && (count == CNT_LAST);

  // Metastability guard on the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= LINE_IDLE_LEVEL;
      sync2 <= LINE_IDLE_LEVEL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Any cycle of agreement restarts the count, so short glitches never pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= LINE_IDLE_LEVEL;
      count  <= '0;
    end else if (sync2 == stable) begin
      count <= '0;
    end else if (flip_c) begin
      stable <= sync2;
      count  <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/ps2_line_conditioner.sv
// Conditions the raw keyboard clock/data pins for the frame shift register.
module ps2_line_conditioner
  import ps2_rx_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned IDLE_CYCLES     = 50000
) (
  input logic                   FCLK,
  input logic                   RST_N,
  ps2_line_conditioner_if.slave bus
);

  localparam int unsigned IW = cnt_width(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);

  logic          clk_stable;
  logic          clk_flip_c;
  logic          data_stable;
  logic          data_flip_unused_c;
  logic          clk_fall_c;
  logic          idle_hit_c;
  logic [IW-1:0] idle_count;

  line_debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clock_filter (
    .clk    (FCLK),
    .rst_n  (RST_N),
    .raw    (bus.RAW_CLOCK),
    .stable (clk_stable),
    .flip_c (clk_flip_c)
  );

  line_debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_data_filter (
    .clk    (FCLK),
    .rst_n  (RST_N),
    .raw    (bus.RAW_DATA),
    .stable (data_stable),
    .flip_c (data_flip_unused_c)
  );

  assign bus.CONTROL_CLOCK  = clk_stable;
  assign bus.DEBOUNCED_DATA = data_stable;

  // Stable clock is high and about to flip: this edge is the 1->0 transition.
  assign clk_fall_c = clk_stable & clk_flip_c;

  // Counter reaches IDLE_CYCLES on this edge.
  assign idle_hit_c = clk_stable & (idle_count == IDLE_LAST);

  // Fall strobe and pre-edge data sample, registered alongside the clock flip.
  always_ff @(posedge FCLK or negedge RST_N) begin
    if (!RST_N) begin
      bus.FALL_STROBE  <= 1'b0;
      bus.DATA_AT_FALL <= 1'b0;
    end else begin
      bus.FALL_STROBE <= clk_fall_c;
      if (clk_fall_c) begin
        bus.DATA_AT_FALL <= data_stable;
      end
    end
  end

  // Idle timer: counts stable-high clock, saturates, pulses once per timeout.
  always_ff @(posedge FCLK or negedge RST_N) begin
    if (!RST_N) begin
      idle_count      <= '0;
      bus.FRAME_RESET <= 1'b0;
      bus.LINE_IDLE   <= 1'b0;
    end else begin
      if (!clk_stable) begin
        idle_count <= '0;
      end else if (idle_count != IDLE_MAX) begin
        idle_count <= idle_count + IW'(1);
      end
      bus.FRAME_RESET <= idle_hit_c;
      if (clk_fall_c) begin
        bus.LINE_IDLE <= 1'b0;
      end else if (idle_hit_c) begin
        bus.LINE_IDLE <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_line_conditioner.sv
// Directed bench for the line conditioner with a fall-data scoreboard.
module tb_ps2_line_conditioner;
  import ps2_rx_pkg::*;

  localparam int unsigned DEB  = 16;
  localparam int unsigned IDLE = 100;

  logic FCLK;
  logic RST_N;
  int   errors;
  int   checks;
  int   strobe_count;
  int   frame_reset_count;
  logic exp_q[$];

  ps2_line_conditioner_if bus ();

  ps2_line_conditioner #(.DEBOUNCE_CYCLES(DEB), .IDLE_CYCLES(IDLE)) dut (
    .FCLK  (FCLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial FCLK = 1'b0;
  always #5 FCLK = ~FCLK;

  task automatic check1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge FCLK);
  endtask

  // Scoreboard: every fall strobe pops the data bit expected at that fall.
  always @(negedge FCLK) begin
    if (bus.FALL_STROBE === 1'b1) begin
      strobe_count++;
      if (exp_q.size() == 0) begin
        check1("unexpected_strobe", 1'b1, 1'b0);
      end else begin
        check1("data_at_fall", bus.DATA_AT_FALL, exp_q.pop_front());
      end
    end
    if (bus.FRAME_RESET === 1'b1) frame_reset_count++;
  end

  initial begin
    int n;
    int s0;
    int f0;
    int lows;
    logic [10:0] frame;
    errors = 0;
    checks = 0;
    strobe_count = 0;
    frame_reset_count = 0;
    frame = {1'b1, 1'b1, 8'h5A, 1'b0};

    // Reset held while raw lines toggle.
    RST_N = 1'b0;
    bus.RAW_CLOCK = 1'b1;
    bus.RAW_DATA  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      bus.RAW_CLOCK = ~bus.RAW_CLOCK;
      bus.RAW_DATA  = (i % 3) == 0;
    end
    tick(1);
    check1("rst_control_clock", bus.CONTROL_CLOCK, 1'b1);
    check1("rst_debounced_data", bus.DEBOUNCED_DATA, 1'b1);
    check1("rst_fall_strobe", bus.FALL_STROBE, 1'b0);
    check1("rst_data_at_fall", bus.DATA_AT_FALL, 1'b0);
    check1("rst_frame_reset", bus.FRAME_RESET, 1'b0);
    check1("rst_line_idle", bus.LINE_IDLE, 1'b0);

    // Release: idle timer runs straight away.
    bus.RAW_CLOCK = 1'b1;
    bus.RAW_DATA  = 1'b1;
    tick(1);
    RST_N = 1'b1;
    n = 0;
    while (bus.FRAME_RESET !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    checkn("reset_idle_latency", n, IDLE);
    check1("reset_line_idle_set", bus.LINE_IDLE, 1'b1);
    tick(1);
    check1("reset_frame_reset_pulse", bus.FRAME_RESET, 1'b0);
    check1("reset_line_idle_hold", bus.LINE_IDLE, 1'b1);

    // Glitch one cycle shorter than the filter window.
    s0 = strobe_count;
    bus.RAW_CLOCK = 1'b0;
    tick(DEB - 1);
    bus.RAW_CLOCK = 1'b1;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (bus.CONTROL_CLOCK !== 1'b1) lows++;
    end
    checkn("glitch_control_clock_lows", lows, 0);
    checkn("glitch_no_strobe", strobe_count, s0);

    // Clean fall with data low: strobe exactly at edge DEB+2.
    bus.RAW_DATA = 1'b0;
    tick(40);
    exp_q.push_back(1'b0);
    bus.RAW_CLOCK = 1'b0;
    tick(DEB + 1);
    check1("fall_pre_control_clock", bus.CONTROL_CLOCK, 1'b1);
    check1("fall_pre_strobe", bus.FALL_STROBE, 1'b0);
    tick(1);
    check1("fall_control_clock", bus.CONTROL_CLOCK, 1'b0);
    check1("fall_strobe", bus.FALL_STROBE, 1'b1);
    check1("fall_data", bus.DATA_AT_FALL, 1'b0);
    check1("fall_clears_line_idle", bus.LINE_IDLE, 1'b0);
    tick(1);
    check1("fall_post_strobe", bus.FALL_STROBE, 1'b0);

    // Data and clock flip on the same edge: pre-edge data is captured.
    bus.RAW_CLOCK = 1'b1;
    bus.RAW_DATA  = 1'b1;
    tick(40);
    exp_q.push_back(1'b1);
    bus.RAW_CLOCK = 1'b0;
    bus.RAW_DATA  = 1'b0;
    tick(DEB + 2);
    check1("same_edge_strobe", bus.FALL_STROBE, 1'b1);
    check1("same_edge_data_new", bus.DEBOUNCED_DATA, 1'b0);
    check1("same_edge_data_at_fall", bus.DATA_AT_FALL, 1'b1);
    bus.RAW_CLOCK = 1'b1;
    tick(20);

    // Full frame at 60-cycle half periods.
    s0 = strobe_count;
    f0 = frame_reset_count;
    for (int i = 0; i < FRAME_BITS; i++) begin
      bus.RAW_DATA = frame[i];
      exp_q.push_back(frame[i]);
      tick(60);
      bus.RAW_CLOCK = 1'b0;
      tick(60);
      bus.RAW_CLOCK = 1'b1;
    end
    n = 0;
    while (bus.CONTROL_CLOCK !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    checkn("frame_rise_latency", n, DEB + 2);
    checkn("frame_strobe_count", strobe_count - s0, FRAME_BITS);
    checkn("frame_queue_drained", exp_q.size(), 0);

    // Idle timeout after the final rise.
    n = 0;
    while (bus.FRAME_RESET !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    checkn("idle_latency", n, IDLE);
    check1("idle_line_idle", bus.LINE_IDLE, 1'b1);
    tick(150);
    checkn("idle_single_pulse", frame_reset_count - f0, 1);
    check1("idle_line_idle_hold", bus.LINE_IDLE, 1'b1);

    // Next fall drops LINE_IDLE on the strobe edge.
    exp_q.push_back(1'b1);
    bus.RAW_CLOCK = 1'b0;
    tick(DEB + 1);
    check1("idle_pre_fall_line_idle", bus.LINE_IDLE, 1'b1);
    tick(1);
    check1("idle_fall_strobe", bus.FALL_STROBE, 1'b1);
    check1("idle_fall_line_idle", bus.LINE_IDLE, 1'b0);

    // Asynchronous reset part-way through qualifying a fall.
    bus.RAW_CLOCK = 1'b1;
    tick(130);
    check1("async_pre_line_idle", bus.LINE_IDLE, 1'b1);
    bus.RAW_CLOCK = 1'b0;
    tick(12);
    #2;
    RST_N = 1'b0;
    #1;
    check1("async_line_idle", bus.LINE_IDLE, 1'b0);
    check1("async_control_clock", bus.CONTROL_CLOCK, 1'b1);
    check1("async_fall_strobe", bus.FALL_STROBE, 1'b0);
    tick(2);
    RST_N = 1'b1;
    exp_q.push_back(1'b1);
    tick(DEB + 1);
    check1("async_requal_pre", bus.CONTROL_CLOCK, 1'b1);
    tick(1);
    check1("async_requal_clock", bus.CONTROL_CLOCK, 1'b0);
    check1("async_requal_strobe", bus.FALL_STROBE, 1'b1);

    bus.RAW_CLOCK = 1'b1;
    tick(30);
    checkn("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
